rs232_rx: RTL and testbench
===========================

RS232_RX -- requirements
Module: rs232_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, clk_ref frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, serial bit rate in bit/s.
REQ-003 clk_ref  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 i_rx_pin  input  1  asynchronous serial line, idle high.
REQ-006 o_rx_dat  output  8  last correctly received byte.
REQ-007 o_rx_done  output  1  one-cycle pulse, o_rx_dat newly valid.
REQ-008 o_rx_frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-009 o_rx_parity_err  output  1  one-cycle pulse, parity mismatch; constant 0 without RX_PARITY_EN.
REQ-010 o_rx_busy  output  1  high in every state except IDLE.

Function
REQ-011 BIT_CNT = CLK_FREQ/BAUD_RATE (integer division, 434 at defaults); HALF_CNT = BIT_CNT/2 (217).
REQ-012 i_rx_pin shall pass through a 2-FF synchronizer; a third register gives the previous value for falling-edge detection.
REQ-013 States: IDLE, START, DATA, PARITY (RX_PARITY_EN only), STOP.
REQ-014 IDLE: synchronized falling edge -> START, baud counter cleared to 0.
REQ-015 START: at count HALF_CNT-1 sample line; low -> DATA with counter cleared; high -> IDLE (glitch rejected, no output pulse).
REQ-016 DATA: sample at each count BIT_CNT-1, shift in LSB first; after the 8th sample -> PARITY if enabled, else STOP.
REQ-017 PARITY: sample at count BIT_CNT-1, compare against even parity of the 8 data bits, store result, -> STOP.
REQ-018 STOP: sample at count BIT_CNT-1, then -> IDLE in the same transition.
REQ-019 Stop high and no parity error: o_rx_dat loaded and o_rx_done pulsed exactly one cycle, in the cycle after the stop sample.
REQ-020 Stop low: o_rx_frame_err pulsed one cycle; o_rx_dat unchanged; no o_rx_done.
REQ-021 Parity mismatch with stop high: o_rx_parity_err pulsed one cycle; o_rx_dat unchanged; no o_rx_done. Stop low takes precedence: frame_err only.
REQ-022 The baud counter shall wrap to 0 on each sample point and never exceed BIT_CNT-1.
REQ-023 Line held low after a framing error (break) shall not start a new frame until a fresh high-to-low edge.
REQ-024 A falling edge during START/DATA/PARITY/STOP shall be ignored; a new start is recognised only in IDLE.
REQ-025 Back-to-back frames (start bit immediately after stop bit) shall be received without loss.

Reset
REQ-026 rst high shall immediately force state IDLE, counters, shift register and synchronizer (to 1) to reset values, independent of clk_ref.
REQ-027 Reset values: o_rx_dat 8'h00, o_rx_done 0, o_rx_frame_err 0, o_rx_parity_err 0, o_rx_busy 0.
REQ-028 Reset mid-frame shall discard the partial byte; no pulse shall follow reset release.

Configuration
REQ-029 Macro RS232_RX_PARITY_EN defined: frame = start, 8 data, even parity, stop (11 bits); PARITY state and o_rx_parity_err active.
REQ-030 Macro RS232_RX_PARITY_EN undefined: frame = start, 8 data, stop (10 bits); no PARITY state; o_rx_parity_err tied 0; port list unchanged.

Verification
REQ-031 Defaults, no parity; bench drives 8'hAA at 434 cycles/bit -> o_rx_done one pulse ~9.5 bit times after start edge, o_rx_dat = 8'hAA, no error pulses.
REQ-032 Back-to-back frames 8'hB8 then 8'h3B with zero idle gap -> two o_rx_done pulses, o_rx_dat 8'hB8 then 8'h3B.
REQ-033 Low glitch of 100 cycles on idle line -> return to IDLE, no pulses, o_rx_busy high only ~217 cycles.
REQ-034 Frame 8'h55 with stop bit forced low -> o_rx_frame_err one pulse, o_rx_dat keeps previous value, no o_rx_done.
REQ-035 RS232_RX_PARITY_EN defined; 8'h3B sent with parity 1 -> o_rx_done, 8'h3B; resent with parity 0 -> o_rx_parity_err pulse, no o_rx_done.
REQ-036 rst asserted during bit 4 of a frame for 3 cycles -> all outputs 0 immediately, no pulse for that frame; next clean 8'hAA frame received correctly.

Source files
------------

// File: rtl/rs232_rx.sv
// rs232_rx: 8-bit asynchronous serial receiver, LSB first, one stop bit.
// Optional even-parity bit when the RS232_RX_PARITY_EN macro is defined;
// otherwise o_rx_parity_err is tied low and the frame is 10 bits long.
// Bits are sampled in mid-bit using a baud counter clocked by clk_ref.
module rs232_rx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk_ref,
    input  logic       rst,
    input  logic       i_rx_pin,
    output logic [7:0] o_rx_dat,
    output logic       o_rx_done,
    output logic       o_rx_frame_err,
    output logic       o_rx_parity_err,
    output logic       o_rx_busy
);

    localparam int BIT_CNT  = CLK_FREQ / BAUD_RATE;
    localparam int HALF_CNT = BIT_CNT / 2;
    localparam int CNT_W    = $clog2(BIT_CNT);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef RS232_RX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic             rx_fall;
    logic [2:0]       state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             cnt_last;
    logic             half_last;
`ifdef RS232_RX_PARITY_EN
    logic             par_err_q;
`endif

    // Two-flop synchronizer plus a history flop for falling-edge detection.
    // NOTE: the chain resets to 1 (idle line level) so reset release never
    // looks like a start edge; sequential state always uses non-blocking <=.
    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_rx_pin;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall   = rx_prev & ~rx_sync;
    assign cnt_last  = (baud_cnt == BIT_LAST);
    assign half_last = (baud_cnt == HALF_LAST);
    assign o_rx_busy = (state != IDLE);

`ifndef RS232_RX_PARITY_EN
    assign o_rx_parity_err = 1'b0;
`endif

    // Receive FSM: mid-bit sampling, shifting, and one-cycle result pulses.
    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            baud_cnt       <= '0;
            bit_idx        <= '0;
            shift          <= '0;
            o_rx_dat       <= '0;
            o_rx_done      <= 1'b0;
            o_rx_frame_err <= 1'b0;
`ifdef RS232_RX_PARITY_EN
            par_err_q       <= 1'b0;
            o_rx_parity_err <= 1'b0;
`endif
        end else begin
            // Pulses default low so each lasts exactly one cycle.
            o_rx_done      <= 1'b0;
            o_rx_frame_err <= 1'b0;
`ifdef RS232_RX_PARITY_EN
            o_rx_parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (rx_fall)
                        state <= START;
                end
                START: begin
                    if (half_last) begin
                        // Line back high at mid start bit: a glitch, drop it.
                        baud_cnt <= '0;
                        state    <= rx_sync ? IDLE : DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_last) begin
                        baud_cnt <= '0;
                        shift    <= {rx_sync, shift[7:1]};
                        bit_idx  <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
`ifdef RS232_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef RS232_RX_PARITY_EN
                PARITY: begin
                    if (cnt_last) begin
                        baud_cnt  <= '0;
                        par_err_q <= rx_sync ^ (^shift);
                        state     <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cnt_last) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                        // A low stop bit outranks a parity mismatch.
                        if (!rx_sync) begin
                            o_rx_frame_err <= 1'b1;
`ifdef RS232_RX_PARITY_EN
                        end else if (par_err_q) begin
                            o_rx_parity_err <= 1'b1;
`endif
                        end else begin
                            o_rx_dat  <= shift;
                            o_rx_done <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    baud_cnt <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs232_rx.sv
// tb_rs232_rx: drives serial frames on i_rx_pin and compares the receiver's
// pulses and data against a frame-level reference model.
module tb_rs232_rx;

    localparam int BIT = 50_000_000 / 115200;
`ifdef RS232_RX_PARITY_EN
    localparam int LAT_EXP = 4126 + BIT;
`else
    localparam int LAT_EXP = 4126;
`endif

    logic       clk_ref = 1'b0;
    logic       rst;
    logic       rx_pin;
    logic [7:0] rx_dat;
    logic       rx_done;
    logic       rx_frame_err;
    logic       rx_parity_err;
    logic       rx_busy;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc           = 0;
    int done_cnt      = 0;
    int ferr_cnt      = 0;
    int perr_cnt      = 0;
    int busy_cnt      = 0;
    int last_done_cyc = 0;

    logic [7:0] model_dat = 8'h00;

    rs232_rx dut (
        .clk_ref        (clk_ref),
        .rst            (rst),
        .i_rx_pin       (rx_pin),
        .o_rx_dat       (rx_dat),
        .o_rx_done      (rx_done),
        .o_rx_frame_err (rx_frame_err),
        .o_rx_parity_err(rx_parity_err),
        .o_rx_busy      (rx_busy)
    );

    always #10 clk_ref = ~clk_ref;

    // Cycle counter used for latency measurement.
    always @(posedge clk_ref) cyc <= cyc + 1;

    // Monitor: count high samples of each output on the inactive edge.
    always @(negedge clk_ref) begin
        if (rx_done) begin
            done_cnt      = done_cnt + 1;
            last_done_cyc = cyc;
        end
        if (rx_frame_err)  ferr_cnt = ferr_cnt + 1;
        if (rx_parity_err) perr_cnt = perr_cnt + 1;
        if (rx_busy)       busy_cnt = busy_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx_pin = v;
        repeat (n) @(negedge clk_ref);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit,
                              output int start_cyc);
        start_cyc = cyc;
        hold(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(d[i], BIT);
`ifdef RS232_RX_PARITY_EN
        hold(par_bit, BIT);
`else
        if (par_bit === 1'bx) $display("unexpected X parity argument");
`endif
        hold(stop_bit, BIT);
    endtask

    // Sends one frame and checks its outcome against the frame-level rules:
    // stop low -> frame error; else parity mismatch -> parity error; else data.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic stop_bit,
                             input logic par_bit, output int start_cyc);
        int  d0, f0, p0;
        logic par_ok;
        int  e_done, e_ferr, e_perr;
        d0 = done_cnt; f0 = ferr_cnt; p0 = perr_cnt;
`ifdef RS232_RX_PARITY_EN
        par_ok = (par_bit == ^d);
`else
        par_ok = 1'b1;
`endif
        e_ferr = stop_bit ? 0 : 1;
        e_perr = (stop_bit && !par_ok) ? 1 : 0;
        e_done = (stop_bit && par_ok) ? 1 : 0;
        if (e_done == 1) model_dat = d;
        send_frame(d, stop_bit, par_bit, start_cyc);
        check($sformatf("%s_done", tag), done_cnt - d0, e_done);
        check($sformatf("%s_frame_err", tag), ferr_cnt - f0, e_ferr);
        check($sformatf("%s_parity_err", tag), perr_cnt - p0, e_perr);
        check($sformatf("%s_dat", tag), rx_dat, model_dat);
    endtask

    initial begin
        int sc;
        int d0, f0, p0, b0;
        int lat;
        int nb;

        // Reset state.
        rst    = 1'b1;
        rx_pin = 1'b1;
        #1;
        check("rst_dat", rx_dat, 8'h00);
        check("rst_done", rx_done, 0);
        check("rst_frame_err", rx_frame_err, 0);
        check("rst_parity_err", rx_parity_err, 0);
        check("rst_busy", rx_busy, 0);
        repeat (5) @(negedge clk_ref);
        rst = 1'b0;
        hold(1'b1, 50);

        // Single clean frame with latency measurement.
        run_frame("aa", 8'hAA, 1'b1, ^8'hAA, sc);
        lat = last_done_cyc - sc;
        check("aa_latency", (lat >= LAT_EXP - 8 && lat <= LAT_EXP + 8), 1);
        hold(1'b1, 20);

        // Back-to-back frames with zero idle gap.
        run_frame("b2b_b8", 8'hB8, 1'b1, ^8'hB8, sc);
        run_frame("b2b_3b", 8'h3B, 1'b1, ^8'h3B, sc);
        hold(1'b1, 20);

        // Short low glitch is rejected after half a bit.
        d0 = done_cnt; f0 = ferr_cnt; p0 = perr_cnt; b0 = busy_cnt;
        hold(1'b0, 100);
        hold(1'b1, 600);
        nb = busy_cnt - b0;
        check("glitch_busy_len", (nb >= 215 && nb <= 220), 1);
        check("glitch_pulses", (done_cnt - d0) + (ferr_cnt - f0) + (perr_cnt - p0), 0);
        check("glitch_idle", rx_busy, 0);

        // Framing error, then a held-low break must not start a frame.
        run_frame("ferr_55", 8'h55, 1'b0, ^8'h55, sc);
        d0 = done_cnt; f0 = ferr_cnt; p0 = perr_cnt; b0 = busy_cnt;
        hold(1'b0, 2 * BIT);
        check("break_busy", busy_cnt - b0, 0);
        check("break_pulses", (done_cnt - d0) + (ferr_cnt - f0) + (perr_cnt - p0), 0);
        hold(1'b1, 20);

`ifdef RS232_RX_PARITY_EN
        // Correct and wrong parity for 8'h3B (five ones -> parity bit 1).
        run_frame("par_ok", 8'h3B, 1'b1, 1'b1, sc);
        hold(1'b1, 20);
        run_frame("par_bad", 8'h3B, 1'b1, 1'b0, sc);
        hold(1'b1, 20);
`endif

        // Reset during bit 4 of a frame discards it.
        hold(1'b0, BIT);
        for (int i = 0; i < 4; i++) hold(bit'(8'hAA >> i), BIT);
        hold(1'b0, 200);
        rst    = 1'b1;
        rx_pin = 1'b1;
        #1;
        model_dat = 8'h00;
        check("midrst_dat", rx_dat, model_dat);
        check("midrst_busy", rx_busy, 0);
        check("midrst_done", rx_done, 0);
        check("midrst_frame_err", rx_frame_err, 0);
        repeat (3) @(negedge clk_ref);
        rst = 1'b0;
        d0 = done_cnt; f0 = ferr_cnt; p0 = perr_cnt; b0 = busy_cnt;
        hold(1'b1, 1000);
        check("post_rst_pulses", (done_cnt - d0) + (ferr_cnt - f0) + (perr_cnt - p0), 0);
        check("post_rst_busy", busy_cnt - b0, 0);
        run_frame("post_rst_aa", 8'hAA, 1'b1, ^8'hAA, sc);
        hold(1'b1, 20);

        // Randomized frames: random data, occasional bad stop/parity, random gaps.
        for (int k = 0; k < 5; k++) begin
            logic [7:0] d;
            logic       stop_bit;
            logic       par_bit;
            int         gap;
            d        = 8'($urandom);
            stop_bit = ($urandom_range(0, 3) != 0);
            par_bit  = (^d) ^ ($urandom_range(0, 3) == 0);
            run_frame($sformatf("rnd%0d", k), d, stop_bit, par_bit, sc);
            gap = stop_bit ? $urandom_range(0, 40) : $urandom_range(5, 40);
            if (gap > 0) hold(1'b1, gap);
        end
        hold(1'b1, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
